// File: rtl/reg_list_sequencer_pkg.sv
// Shared encodings for the multi-register transfer sequencer: op codes,
// FSM states, special register indices and a list popcount helper.
package reg_list_sequencer_pkg;

  // Special register indices in the core register file.
  localparam logic [3:0] SP_I = 4'd13;
  localparam logic [3:0] LR_I = 4'd14;
  localparam logic [3:0] PC_I = 4'd15;

  typedef enum logic [1:0] {
    OP_STM  = 2'b00,
    OP_LDM  = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Loads are LDM and POP; everything else reads the register file.
  function automatic logic is_load(input op_t op);
    return (op == OP_LDM) || (op == OP_POP);
  endfunction

  // Number of registers named in a 9-bit list.
  function automatic logic [3:0] popcount9(input logic [8:0] list);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) n = n + {3'd0, list[i]};
    return n;
  endfunction

endpackage

// File: rtl/reg_list_scan.sv
// Combinational scan of a register list: lowest set register index
// (bit8 remapped to LR or PC), a valid flag and the register count.
module reg_list_scan
  import reg_list_sequencer_pkg::*;
(
  input  logic [8:0] list,
  input  logic       hi_is_pc,
  output logic [3:0] idx,
  output logic       valid,
  output logic [3:0] count
);

  // Descending walk so the lowest set bit is the last one to win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx   = '0;
    valid = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      if (list[i]) begin
        valid = 1'b1;
        idx   = (i == 8) ? (hi_is_pc ? PC_I : LR_I) : 4'(i);
      end
    end
    count = popcount9(list);
  end

endmodule

// File: rtl/reg_list_sequencer.sv
// PUSH/POP/LDM/STM sequencer: walks a register list one beat per register,
// moving data between the core register file and the data-memory bus, then
// writes back SP or the base register.
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [8:0]    reg_list,
  input  logic [2:0]    base_reg,
  input  logic [31:0]   base_val,
  input  logic [31:0]   sp_val,
  output logic          busy,
  output logic          done,
  output logic [3:0]    addr_Rs,
  input  logic [31:0]   rs_data,
  output logic          ld_rd,
  output logic [3:0]    addr_Rd,
  output logic [31:0]   w_Rd,
  output logic          ld_sp,
  output logic [31:0]   w_SP,
  output logic          ld_pc,
  output logic [31:0]   w_PC,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  state_t      state;
  op_t         op_q;
  logic [8:0]  list_q;        // registers still to transfer
  logic [2:0]  base_reg_q;
  logic        base_wb_q;     // LDM skips base writeback if the base was loaded
  logic [31:0] addr_q;        // current beat address, final address after XFER
  logic [31:0] start_addr_q;

  logic [3:0]  cur_idx;
  logic        cur_valid;
  logic [3:0]  cur_count;

  logic [8:0]  in_list;
  logic [3:0]  in_count;
  logic [31:0] in_addr;
  logic        is_store;

  reg_list_scan u_scan (
    .list     (list_q),
    .hi_is_pc (op_q == OP_POP),
    .idx      (cur_idx),
    .valid    (cur_valid),
    .count    (cur_count)
  );

  // Request decode: bit8 only has meaning for PUSH/POP; start address per op.
  always_comb begin
    in_list  = ((op == OP_STM) || (op == OP_LDM)) ? {1'b0, reg_list[7:0]} : reg_list;
    in_count = popcount9(in_list);
    case (op)
      OP_PUSH: in_addr = sp_val - {26'd0, in_count, 2'b00};
      OP_POP:  in_addr = sp_val;
      default: in_addr = base_val;
    endcase
    is_store = !is_load(op_q);
  end

  // Sequencer state: accept, one beat per ack, writeback, completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state        <= IDLE;
      op_q         <= OP_STM;
      list_q       <= '0;
      base_reg_q   <= '0;
      base_wb_q    <= 1'b0;
      addr_q       <= '0;
      start_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q         <= op_t'(op);
            list_q       <= in_list;
            base_reg_q   <= base_reg;
            base_wb_q    <= (op == OP_LDM) ? !reg_list[base_reg] : 1'b1;
            addr_q       <= in_addr;
            start_addr_q <= in_addr;
            state        <= (in_count == 4'd0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (mem_ack) begin
            list_q <= list_q & (list_q - 9'd1);  // drop the lowest set bit
            addr_q <= addr_q + 32'd4;
            if (cur_count == 4'd1) state <= WB;
          end
        end
        WB:      state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state; load enables follow mem_ack within the beat.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    addr_Rs   = '0;
    ld_rd     = 1'b0;
    addr_Rd   = '0;
    w_Rd      = '0;
    ld_sp     = 1'b0;
    w_SP      = '0;
    ld_pc     = 1'b0;
    w_PC      = '0;
    case (state)
      XFER: begin
        mem_req  = cur_valid;
        mem_addr = AW'(addr_q);
        if (is_store) begin
          mem_we    = 1'b1;
          addr_Rs   = cur_idx;
          mem_wdata = DW'(rs_data);
        end else if (mem_ack) begin
          if (cur_idx == PC_I) begin
            ld_pc = 1'b1;
            w_PC  = 32'(mem_rdata) & ~32'd1;
          end else begin
            ld_rd   = 1'b1;
            addr_Rd = cur_idx;
            w_Rd    = 32'(mem_rdata);
          end
        end
      end
      WB: begin
        case (op_q)
          OP_PUSH: begin
            ld_sp = 1'b1;
            w_SP  = start_addr_q;
          end
          OP_POP: begin
            ld_sp = 1'b1;
            w_SP  = addr_q;
          end
          default: begin
            if (base_wb_q) begin
              ld_rd   = 1'b1;
              addr_Rd = {1'b0, base_reg_q};
              w_Rd    = addr_q;
            end
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule
